// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encodings,
// master indices, the timeout fill pattern and small helpers.
package mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GRANT   = 2'd1;
    localparam logic [1:0] ARB_RD_WAIT = 2'd2;

    localparam logic MASTER_M0 = 1'b0;
    localparam logic MASTER_M1 = 1'b1;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    // Fresh arbitration from IDLE: a lone requester wins, a tie goes to the
    // master that did not own the bus last.
    function automatic logic pick_owner(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end
        return req1 ? MASTER_M1 : MASTER_M0;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between m0 (cpu) and m1 (loader/DMA),
// with m1 burst lock and read timeout. Optional MEM_ARB_STATS_EN adds transaction counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_rd_en,
    input  logic          m0_wr_en,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wr_data,
    input  logic [3:0]    m0_wr_mask,
    output logic          m0_gnt,
    output logic [31:0]   m0_rd_data,
    output logic          m0_rd_valid,
    input  logic          m1_rd_en,
    input  logic          m1_wr_en,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wr_data,
    input  logic [3:0]    m1_wr_mask,
    output logic          m1_gnt,
    output logic [31:0]   m1_rd_data,
    output logic          m1_rd_valid,
    input  logic          m1_lock,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wr_data,
    output logic [3:0]    mem_wr_mask,
    input  logic [31:0]   mem_rd_data,
    input  logic          mem_rd_valid,
    output logic          rd_timeout
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]   m0_txn_cnt,
    output logic [15:0]   m1_txn_cnt,
    output logic [15:0]   timeout_cnt
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_reg, state_next;
    logic          owner_reg, owner_next;
    logic          last_reg, last_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic          req0, req1, other_req;
    logic          own_rd, own_wr, own_req;
    logic [AW-1:0] own_addr;
    logic [31:0]   own_wr_data;
    logic [3:0]    own_wr_mask;
    logic          in_grant, in_wait;
    logic          wr_done, rd_hit, rd_tmo, txn_end;
    logic          gnt_any, rd_valid_any;
    logic [31:0]   rd_data_any;

    assign req0 = m0_rd_en | m0_wr_en;
    assign req1 = m1_rd_en | m1_wr_en;

    // Everything below is the owner's view; the other master's inputs never reach memory.
    assign own_wr      = (owner_reg == MASTER_M1) ? m1_wr_en : m0_wr_en;
    assign own_rd      = ((owner_reg == MASTER_M1) ? m1_rd_en : m0_rd_en) & ~own_wr;
    assign own_req     = own_rd | own_wr;
    assign other_req   = (owner_reg == MASTER_M1) ? req0 : req1;
    assign own_addr    = (owner_reg == MASTER_M1) ? m1_addr : m0_addr;
    assign own_wr_data = (owner_reg == MASTER_M1) ? m1_wr_data : m0_wr_data;
    assign own_wr_mask = (owner_reg == MASTER_M1) ? m1_wr_mask : m0_wr_mask;

    assign in_grant = (state_reg == ARB_GRANT);
    assign in_wait  = (state_reg == ARB_RD_WAIT);

    assign wr_done  = in_grant & own_wr;
    assign rd_hit   = in_wait & mem_rd_valid;
    assign rd_tmo   = in_wait & ~mem_rd_valid & (cnt_reg == CW'(TIMEOUT));
    assign txn_end  = wr_done | rd_hit | rd_tmo;

    assign gnt_any      = (in_grant & own_req) | in_wait;
    assign rd_valid_any = rd_hit | rd_tmo;
    assign rd_data_any  = rd_hit ? mem_rd_data : (rd_tmo ? DEAD_BEEF : 32'd0);

    assign m0_gnt      = gnt_any & (owner_reg == MASTER_M0);
    assign m1_gnt      = gnt_any & (owner_reg == MASTER_M1);
    assign m0_rd_valid = rd_valid_any & (owner_reg == MASTER_M0);
    assign m1_rd_valid = rd_valid_any & (owner_reg == MASTER_M1);
    assign m0_rd_data  = (owner_reg == MASTER_M0) ? rd_data_any : 32'd0;
    assign m1_rd_data  = (owner_reg == MASTER_M1) ? rd_data_any : 32'd0;
    assign rd_timeout  = rd_tmo;

    assign mem_rd_en   = in_grant & own_rd;
    assign mem_wr_en   = in_grant & own_wr;
    assign mem_addr    = (in_grant & own_req) ? own_addr : '0;
    assign mem_wr_data = mem_wr_en ? own_wr_data : 32'd0;
    assign mem_wr_mask = mem_wr_en ? own_wr_mask : 4'd0;

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (req0 | req1) begin
                    owner_next = pick_owner(req0, req1, last_reg);
                    state_next = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (own_rd) begin
                    state_next = ARB_RD_WAIT;
                    cnt_next   = '0;
                end else if (!own_wr) begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_RD_WAIT: begin
                if (!rd_valid_any) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = ARB_IDLE;
        endcase
        // End of transaction: lock first, then fairness, then the owner itself.
        if (txn_end) begin
            last_next = owner_reg;
            if (owner_reg == MASTER_M1 && m1_lock) begin
                owner_next = MASTER_M1;
                state_next = ARB_GRANT;
            end else if (other_req) begin
                owner_next = ~owner_reg;
                state_next = ARB_GRANT;
            end else if (own_req) begin
                state_next = ARB_GRANT;
            end else begin
                state_next = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ARB_IDLE;
            owner_reg <= MASTER_M0;
            last_reg  <= MASTER_M1;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] m0_txn_cnt_reg, m1_txn_cnt_reg, timeout_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_txn_cnt_reg  <= '0;
            m1_txn_cnt_reg  <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            if (txn_end && owner_reg == MASTER_M0) begin
                m0_txn_cnt_reg <= sat_inc16(m0_txn_cnt_reg);
            end
            if (txn_end && owner_reg == MASTER_M1) begin
                m1_txn_cnt_reg <= sat_inc16(m1_txn_cnt_reg);
            end
            if (rd_tmo) begin
                timeout_cnt_reg <= sat_inc16(timeout_cnt_reg);
            end
        end
    end

    assign m0_txn_cnt  = m0_txn_cnt_reg;
    assign m1_txn_cnt  = m1_txn_cnt_reg;
    assign timeout_cnt = timeout_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter: transaction-level master agents, a bus-side
// memory responder and a scoreboard memory built only from what the masters intended to write.
module tb_mem_arbiter;

    localparam int AW      = 16;
    localparam int TIMEOUT = 15;
    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_rd_en, m0_wr_en, m1_rd_en, m1_wr_en, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr, mem_addr;
    logic [31:0]   m0_wr_data, m1_wr_data, mem_wr_data, mem_rd_data;
    logic [3:0]    m0_wr_mask, m1_wr_mask, mem_wr_mask;
    logic          m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid;
    logic [31:0]   m0_rd_data, m1_rd_data;
    logic          mem_rd_en, mem_wr_en, mem_rd_valid, rd_timeout;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   m0_txn_cnt, m1_txn_cnt, timeout_cnt;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr),
        .m0_wr_data(m0_wr_data), .m0_wr_mask(m0_wr_mask),
        .m0_gnt(m0_gnt), .m0_rd_data(m0_rd_data), .m0_rd_valid(m0_rd_valid),
        .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr),
        .m1_wr_data(m1_wr_data), .m1_wr_mask(m1_wr_mask),
        .m1_gnt(m1_gnt), .m1_rd_data(m1_rd_data), .m1_rd_valid(m1_rd_valid),
        .m1_lock(m1_lock),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .rd_timeout(rd_timeout)
`ifdef MEM_ARB_STATS_EN
        , .m0_txn_cnt(m0_txn_cnt), .m1_txn_cnt(m1_txn_cnt), .timeout_cnt(timeout_cnt)
`endif
    );

    typedef struct {
        logic          wr;
        logic          both;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    mask;
    } op_t;

    int total = 0;
    int bad   = 0;

    // agent state, one slot per master
    logic          busy [2];
    op_t           cur [2];
    logic          rd_issued [2];
    logic          exp_tmo [2];
    int            exp_done [2];
    int            start_cyc [2];
    int            last_issue [2];
    int            last_done [2];
    logic [31:0]   last_rdata [2];
    int            comp [2];
    int            tmo_cnt;
    op_t           q0[$];
    op_t           q1[$];
    int            ord[$];

    logic [31:0]   ref_mem [64];   // what masters meant to store
    logic [31:0]   mem_arr [64];   // what the memory actually received
    int            cyc = 0;
    int            resp_timer = 0;
    int            resp_word = 0;
    int            resp_mode = 1;   // 0 random delay/drop, 1 always next cycle, 2 never answer
    logic          rnd_mode = 1'b0;
    logic          lock_force = 1'b0;
    logic          spur = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic op_t mk(input logic wr, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
        op_t o;
        o.wr = wr; o.both = 1'b0; o.addr = a; o.data = d; o.mask = m;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.wr   = 1'($urandom % 2);
        o.both = o.wr && ($urandom % 4 == 0);
        o.addr = AW'({$urandom % 64, 2'b00});
        o.data = $urandom;
        o.mask = 4'($urandom);
        return o;
    endfunction

    task automatic clear_bench();
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; rd_issued[i] = 1'b0; comp[i] = 0;
        end
        q0.delete(); q1.delete();
        tmo_cnt = 0; resp_timer = 0; spur = 1'b0;
        mem_rd_valid = 1'b0; mem_rd_data = 32'd0;
        m0_rd_en = 0; m0_wr_en = 0; m1_rd_en = 0; m1_wr_en = 0; m1_lock = 0;
        m0_addr = '0; m1_addr = '0; m0_wr_data = 0; m1_wr_data = 0; m0_wr_mask = 0; m1_wr_mask = 0;
    endtask

    // One clock: load agent ops, drive masters and responder at negedge, then score the cycle.
    task automatic tick();
        logic        g, rv, have, exp_v, exp_tmo_now, exp_mrd, exp_mwr;
        logic [31:0] rdat;
        int          cur_delay, w;
        op_t         o;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!busy[i]) begin
                have = 1'b0;
                if (i == 0 && q0.size() > 0) begin o = q0.pop_front(); have = 1'b1; end
                else if (i == 1 && q1.size() > 0) begin o = q1.pop_front(); have = 1'b1; end
                else if (rnd_mode && ($urandom % 2 == 0)) begin o = rand_op(); have = 1'b1; end
                if (have) begin
                    cur[i] = o; busy[i] = 1'b1; rd_issued[i] = 1'b0; start_cyc[i] = cyc;
                end
            end
        end
        m0_rd_en   = busy[0] && (!cur[0].wr || cur[0].both);
        m0_wr_en   = busy[0] && cur[0].wr;
        m0_addr    = busy[0] ? cur[0].addr : AW'($urandom);
        m0_wr_data = busy[0] ? cur[0].data : $urandom;
        m0_wr_mask = busy[0] ? cur[0].mask : 4'($urandom);
        m1_rd_en   = busy[1] && (!cur[1].wr || cur[1].both);
        m1_wr_en   = busy[1] && cur[1].wr;
        m1_addr    = busy[1] ? cur[1].addr : AW'($urandom);
        m1_wr_data = busy[1] ? cur[1].data : $urandom;
        m1_wr_mask = busy[1] ? cur[1].mask : 4'($urandom);
        m1_lock    = rnd_mode ? ($urandom % 3 == 0) : (lock_force && (busy[1] || q1.size() > 0));
        if (spur) begin
            mem_rd_valid = 1'b1; mem_rd_data = $urandom; spur = 1'b0;
        end else if (resp_timer == 1) begin
            mem_rd_valid = 1'b1; mem_rd_data = mem_arr[resp_word]; resp_timer = 0;
        end else begin
            if (resp_timer > 1) resp_timer--;
            mem_rd_valid = 1'b0; mem_rd_data = $urandom;
        end
        case (resp_mode)
            1:       cur_delay = 1;
            2:       cur_delay = 0;
            default: cur_delay = ($urandom % 8 == 0) ? 0 : 1 + int'($urandom % 4);
        endcase
        #1;
        exp_tmo_now = 1'b0; exp_mrd = 1'b0; exp_mwr = 1'b0;
        check("gnt_onehot", {31'd0, m0_gnt & m1_gnt}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            g    = (i == 0) ? m0_gnt : m1_gnt;
            rv   = (i == 0) ? m0_rd_valid : m1_rd_valid;
            rdat = (i == 0) ? m0_rd_data : m1_rd_data;
            w    = int'(cur[i].addr[7:2]);
            exp_v = busy[i] && !cur[i].wr && rd_issued[i] && (cyc == exp_done[i]);
            check($sformatf("m%0d_rd_valid", i), {31'd0, rv}, {31'd0, exp_v});
            if (!exp_v) check($sformatf("m%0d_rd_data_idle", i), rdat, 32'd0);
            if (busy[i] && !cur[i].wr && rd_issued[i]) begin
                check($sformatf("m%0d_gnt_hold", i), {31'd0, g}, 32'd1);
                if (exp_v) begin
                    check($sformatf("m%0d_rd_data", i), rdat, exp_tmo[i] ? BEEF : ref_mem[w]);
                    if (exp_tmo[i]) begin exp_tmo_now = 1'b1; tmo_cnt++; end
                    last_rdata[i] = rdat; last_done[i] = cyc;
                    busy[i] = 1'b0; comp[i]++; ord.push_back(i);
                end
            end else if (g && !busy[i]) begin
                check($sformatf("m%0d_gnt_no_req", i), {31'd0, g}, 32'd0);
            end else if (g) begin
                check($sformatf("m%0d_mem_addr", i), {16'd0, mem_addr}, {16'd0, cur[i].addr});
                if (cur[i].wr) begin
                    exp_mwr = 1'b1;
                    check($sformatf("m%0d_wr_data", i), mem_wr_data, cur[i].data);
                    check($sformatf("m%0d_wr_mask", i), {28'd0, mem_wr_mask}, {28'd0, cur[i].mask});
                    ref_mem[w] = merge(ref_mem[w], cur[i].data, cur[i].mask);
                    last_done[i] = cyc; busy[i] = 1'b0; comp[i]++; ord.push_back(i);
                end else begin
                    exp_mrd = 1'b1; rd_issued[i] = 1'b1; last_issue[i] = cyc;
                    exp_tmo[i]  = (cur_delay == 0);
                    exp_done[i] = (cur_delay == 0) ? cyc + TIMEOUT + 1 : cyc + cur_delay;
                end
            end
            if (busy[i] && (cyc - start_cyc[i] > 300)) begin
                check($sformatf("m%0d_starved", i), 32'd1, 32'd0);
                busy[i] = 1'b0;
            end
        end
        check("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, exp_mrd});
        check("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, exp_mwr});
        check("rd_timeout", {31'd0, rd_timeout}, {31'd0, exp_tmo_now});
        if (mem_wr_en) mem_arr[mem_addr[7:2]] = merge(mem_arr[mem_addr[7:2]], mem_wr_data, mem_wr_mask);
        if (mem_rd_en) begin
            resp_word  = int'(mem_addr[7:2]);
            resp_timer = cur_delay;
        end
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy[0] || busy[1] || q0.size() > 0 || q1.size() > 0) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) check("wait_bound", 32'd1, 32'd0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_bench();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int e2[4];
        int e3[5];
        int tb;
        int n;
        e2 = '{0, 1, 0, 1};
        e3 = '{1, 1, 1, 1, 0};
        for (int k = 0; k < 64; k++) begin
            ref_mem[k] = 32'h0101_0101 * k;
            mem_arr[k] = 32'h0101_0101 * k;
        end
        rst_n = 1'b1;
        clear_bench();
        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs", {25'd0, m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid, mem_rd_en, mem_wr_en, rd_timeout}, 32'd0);
        check("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // m0 read at 0x0080, memory answers next cycle
        ref_mem[32] = 32'h1234_5678; mem_arr[32] = 32'h1234_5678;
        resp_mode = 1;
        q0.push_back(mk(1'b0, 16'h0080, 32'd0, 4'd0));
        wait_idle(50);
        check("t1_rd_latency", last_done[0] - start_cyc[0], 32'd2);
        check("t1_rd_data", last_rdata[0], 32'h1234_5678);
        check("t1_m1_untouched", comp[1], 32'd0);

        // stray mem_rd_valid while idle must be ignored
        spur = 1'b1;
        tick();
        tick();

        // simultaneous writes after reset: m0 first, then strict alternation
        do_reset();
        ord.delete();
        for (int k = 0; k < 2; k++) begin
            q0.push_back(mk(1'b1, AW'(16 + 4 * k), 32'hA0A0_0000 + k, 4'hF));
            q1.push_back(mk(1'b1, AW'(48 + 4 * k), 32'hB1B1_0000 + k, 4'h5));
        end
        tick();
        tick();
        check("t2_wr_latency", last_done[0] - start_cyc[0], 32'd1);
        wait_idle(50);
        check("t2_order_len", ord.size(), 32'd4);
        for (int k = 0; k < 4 && k < ord.size(); k++) check($sformatf("t2_order%0d", k), ord[k], e2[k]);

        // m1 locked burst of 4 writes keeps the bus while an m0 read waits
        ord.delete();
        lock_force = 1'b1;
        for (int k = 0; k < 4; k++) q1.push_back(mk(1'b1, AW'(64 + 4 * k), $urandom, 4'($urandom)));
        tick();
        q0.push_back(mk(1'b0, 16'h0044, 32'd0, 4'd0));
        wait_idle(80);
        lock_force = 1'b0;
        check("t3_order_len", ord.size(), 32'd5);
        for (int k = 0; k < 5 && k < ord.size(); k++) check($sformatf("t3_order%0d", k), ord[k], e3[k]);
        check("t3_m0_data", last_rdata[0], ref_mem[17]);

        // lost read data: forced completion after TIMEOUT wait cycles
        tb = tmo_cnt;
        resp_mode = 2;
        q0.push_back(mk(1'b0, 16'h0010, 32'd0, 4'd0));
        wait_idle(60);
        check("t4_tmo_count", tmo_cnt - tb, 32'd1);
        check("t4_tmo_wait", last_done[0] - last_issue[0], TIMEOUT + 1);
        check("t4_tmo_data", last_rdata[0], BEEF);

        // asynchronous reset in the middle of RD_WAIT
        q0.push_back(mk(1'b0, 16'h0020, 32'd0, 4'd0));
        n = 0;
        while (!(busy[0] && rd_issued[0]) && n < 10) begin tick(); n++; end
        check("t5_read_issued", {31'd0, rd_issued[0]}, 32'd1);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_zero", {25'd0, m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid, mem_rd_en, mem_wr_en, rd_timeout}, 32'd0);
        clear_bench();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (TIMEOUT + 10) tick();
        check("t5_no_late_valid", comp[0], 32'd0);
        resp_mode = 1;
        q0.push_back(mk(1'b0, 16'h0020, 32'd0, 4'd0));
        wait_idle(50);
        check("t5_after_reset", comp[0], 32'd1);
        check("t5_after_data", last_rdata[0], ref_mem[8]);

        // random traffic with random lock, delays and dropped responses
        resp_mode = 0;
        rnd_mode = 1'b1;
        repeat (2000) tick();
        rnd_mode = 1'b0;
        wait_idle(100);
        check("rnd_m0_progress", {31'd0, comp[0] > 50}, 32'd1);
        check("rnd_m1_progress", {31'd0, comp[1] > 50}, 32'd1);
`ifdef MEM_ARB_STATS_EN
        check("stat_m0_txn", {16'd0, m0_txn_cnt}, comp[0]);
        check("stat_m1_txn", {16'd0, m1_txn_cnt}, comp[1]);
        check("stat_timeout", {16'd0, timeout_cnt}, tmo_cnt);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
